// File: rtl/mem_wb_if.sv
// MEM/WB stage bus: MEM-stage control and data in, write-back results out.
// Stall/flush travel with the bus so the pipeline controller drives them
// alongside the instruction it qualifies.
interface mem_wb_if #(
  parameter int P_RD_W = 5
);
  logic              i_stall;
  logic              i_flush;
  logic              i_mem_valid;
  logic [31:0]       i_mem_instr;
  logic              i_mem_rd_wren;
  logic [1:0]        i_mem_wb_sel;
  logic [31:0]       i_mem_alu_data;
  logic [31:0]       i_mem_pc_four;
  logic [31:0]       i_ld_data;
  logic              o_wb_valid;
  logic [P_RD_W-1:0] o_wb_rd_addr;
  logic              o_wb_rd_wren;
  logic [31:0]       o_wb_data;
  logic              o_misalign;

  modport master (
    output i_stall, i_flush, i_mem_valid, i_mem_instr, i_mem_rd_wren,
           i_mem_wb_sel, i_mem_alu_data, i_mem_pc_four, i_ld_data,
    input  o_wb_valid, o_wb_rd_addr, o_wb_rd_wren, o_wb_data, o_misalign
  );

  modport slave (
    input  i_stall, i_flush, i_mem_valid, i_mem_instr, i_mem_rd_wren,
           i_mem_wb_sel, i_mem_alu_data, i_mem_pc_four, i_ld_data,
    output o_wb_valid, o_wb_rd_addr, o_wb_rd_wren, o_wb_data, o_misalign
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and load formatter. The LSU returns its word one
// cycle after the address, so the MEM-stage control is registered here and
// meets the load word in WB. Byte/half lanes are extracted and extended,
// misaligned loads are flagged (and their write suppressed), and the load
// word is captured on the first stalled edge so WB output stays stable even
// if the LSU moves on.
module mem_wb_stage #(
  parameter int P_HOLD_EN = 1,
  parameter int P_RD_W    = 5
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  mem_wb_if.slave  bus
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic              valid_r;
  logic              rd_wren_r;
  logic [2:0]        funct3_r;
  logic [P_RD_W-1:0] rd_r;
  logic [1:0]        wb_sel_r;
  logic [31:0]       alu_r;
  logic [31:0]       pc4_r;
  logic [31:0]       hold_q_r;
  logic              hold_vld_r;

  logic [31:0]       ld_w_s;
  logic [7:0]        byte_s;
  logic [15:0]       half_s;
  logic [31:0]       fmt_s;
  logic              misalign_s;
  logic [31:0]       data_s;

  // Stage register: flush inserts a bubble, stall holds, otherwise capture MEM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_r   <= 1'b0;
      rd_wren_r <= 1'b0;
      funct3_r  <= 3'b000;
      rd_r      <= '0;
      wb_sel_r  <= 2'b00;
      alu_r     <= 32'h0000_0000;
      pc4_r     <= 32'h0000_0000;
    end else if (bus.i_flush) begin
      valid_r   <= 1'b0;
    end else if (!bus.i_stall) begin
      valid_r   <= bus.i_mem_valid;
      rd_wren_r <= bus.i_mem_rd_wren;
      funct3_r  <= bus.i_mem_instr[14:12];
      rd_r      <= bus.i_mem_instr[7 +: P_RD_W];
      wb_sel_r  <= bus.i_mem_wb_sel;
      alu_r     <= bus.i_mem_alu_data;
      pc4_r     <= bus.i_mem_pc_four;
    end else begin
      valid_r   <= valid_r;
    end
  end

  generate
    if (P_HOLD_EN != 0) begin : g_hold
      // Capture the load word on the first stalled edge of a WB load; release when the stall ends.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          hold_q_r   <= 32'h0000_0000;
          hold_vld_r <= 1'b0;
        end else if (bus.i_flush || !bus.i_stall) begin
          hold_vld_r <= 1'b0;
        end else if (valid_r && (wb_sel_r == SEL_LOAD) && !hold_vld_r) begin
          hold_q_r   <= bus.i_ld_data;
          hold_vld_r <= 1'b1;
        end else begin
          hold_vld_r <= hold_vld_r;
        end
      end
    end else begin : g_no_hold
      assign hold_q_r   = 32'h0000_0000;
      assign hold_vld_r = 1'b0;
    end
  endgenerate

  // Load formatting, misalignment detection and write-back selection.
  always_comb begin
    ld_w_s = hold_vld_r ? hold_q_r : bus.i_ld_data;

    case (alu_r[1:0])
      2'b00:   byte_s = ld_w_s[7:0];
      2'b01:   byte_s = ld_w_s[15:8];
      2'b10:   byte_s = ld_w_s[23:16];
      2'b11:   byte_s = ld_w_s[31:24];
      default: byte_s = ld_w_s[7:0];
    endcase

    half_s = alu_r[1] ? ld_w_s[31:16] : ld_w_s[15:0];

    case (funct3_r)
      F3_LB:   fmt_s = {{24{byte_s[7]}}, byte_s};
      F3_LH:   fmt_s = {{16{half_s[15]}}, half_s};
      F3_LW:   fmt_s = ld_w_s;
      F3_LBU:  fmt_s = {24'h00_0000, byte_s};
      F3_LHU:  fmt_s = {16'h0000, half_s};
      default: fmt_s = 32'h0000_0000;
    endcase

    // Only loads can be misaligned; byte loads never are.
    if (valid_r && (wb_sel_r == SEL_LOAD)) begin
      case (funct3_r)
        F3_LH, F3_LHU: misalign_s = alu_r[0];
        F3_LW:         misalign_s = (alu_r[1:0] != 2'b00);
        default:       misalign_s = 1'b0;
      endcase
    end else begin
      misalign_s = 1'b0;
    end

    case (wb_sel_r)
      SEL_ALU:  data_s = alu_r;
      SEL_LOAD: data_s = fmt_s;
      SEL_PC4:  data_s = pc4_r;
      default:  data_s = 32'h0000_0000;
    endcase
  end

  assign bus.o_wb_valid   = valid_r;
  assign bus.o_wb_data    = valid_r ? data_s : 32'h0000_0000;
  assign bus.o_wb_rd_addr = valid_r ? rd_r : '0;
  assign bus.o_wb_rd_wren = valid_r & rd_wren_r & (rd_r != '0) & ~misalign_s;
  assign bus.o_misalign   = misalign_s;

endmodule
